// File: rtl/pipe_pkg.sv
// pipe_pkg: shared pipeline payload types, default widths and the skid-register state encoding
package pipe_pkg;

   localparam int XLEN   = 32;
   localparam int REG_AW = 5;

   typedef struct packed {
      logic RegWrite;
      logic MemWrite;
      logic MemRead;
      logic Mem2Reg;
   } ex_mem_ctrl_t;

   typedef struct packed {
      ex_mem_ctrl_t      ctrl;
      logic              zero;
      logic [XLEN-1:0]   alu;
      logic [XLEN-1:0]   wdata;
      logic [REG_AW-1:0] rd;
   } ex_mem_payload_t;

   typedef enum logic [1:0] {EMPTY, FULL, SKID} skid_state_t;

   // Side-effecting control bits are suppressed for a bubble; Mem2Reg only steers a mux.
   function automatic ex_mem_ctrl_t bubble_ctrl(input ex_mem_ctrl_t c, input logic v);
      return '{RegWrite: c.RegWrite & v, MemWrite: c.MemWrite & v,
               MemRead: c.MemRead & v, Mem2Reg: c.Mem2Reg};
   endfunction

endpackage

// File: rtl/pipe_skid_reg.sv
// pipe_skid_reg: payload-agnostic valid/ready register with an optional skid entry and flush
module pipe_skid_reg
   import pipe_pkg::*;
#(
   parameter int W    = 8,
   parameter bit SKID = 1'b1
) (
   input  logic         clk_i,
   input  logic         rst_n_i,
   input  logic         flush_i,
   input  logic         valid_i,
   output logic         ready_o,
   input  logic [W-1:0] data_i,
   output logic         valid_o,
   input  logic         ready_i,
   output logic [W-1:0] data_o
);

   skid_state_t  state_q, state_d;
   logic [W-1:0] main_q, skid_q;
   logic         rdy_q, accept, load_main, load_skid, drain_skid;

   // rdy_q doubles as the "out of reset" qualifier when there is no skid entry
   assign valid_o = (state_q != pipe_pkg::EMPTY);
   assign ready_o = SKID ? rdy_q : rdy_q & (ready_i | ~valid_o);
   assign accept  = valid_i & ready_o & ~flush_i;
   assign data_o  = main_q;

   // next state and which register captures what on this edge
   always_comb begin
      state_d    = state_q;
      load_main  = 1'b0;
      load_skid  = 1'b0;
      drain_skid = 1'b0;
      if (flush_i)
         state_d = pipe_pkg::EMPTY;
      else
         case (state_q)
            pipe_pkg::EMPTY: begin
               state_d   = accept ? pipe_pkg::FULL : pipe_pkg::EMPTY;
               load_main = accept;
            end
            pipe_pkg::FULL: begin
               if (ready_i) begin
                  state_d   = accept ? pipe_pkg::FULL : pipe_pkg::EMPTY;
                  load_main = accept;
               end else if (accept && SKID) begin
                  state_d   = pipe_pkg::SKID;
                  load_skid = 1'b1;
               end
            end
            default: begin
               state_d    = ready_i ? pipe_pkg::FULL : pipe_pkg::SKID;
               drain_skid = ready_i;
            end
         endcase
   end

   // state, registered ready and the two payload slots
   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         state_q <= pipe_pkg::EMPTY;
         rdy_q   <= 1'b0;
         main_q  <= '0;
         skid_q  <= '0;
      end else begin
         state_q <= state_d;
         rdy_q   <= (state_d != pipe_pkg::SKID);
         if (load_main)
            main_q <= data_i;
         else if (drain_skid)
            main_q <= skid_q;
         if (load_skid)
            skid_q <= data_i;
      end
   end

endmodule

// File: rtl/ex_mem_stage.sv
// ex_mem_stage: EX/MEM pipeline register with valid/ready back-pressure, flush, bubble gating and stall counter
module ex_mem_stage
   import pipe_pkg::*;
#(
   parameter int XLEN   = pipe_pkg::XLEN,
   parameter int REG_AW = pipe_pkg::REG_AW,
   parameter bit SKID   = 1'b1,
   parameter int CNT_W  = 16
) (
   input  logic              clk_i,
   input  logic              rst_n_i,
   input  logic              flush_i,
   input  logic              valid_i,
   output logic              ready_o,
   input  logic              RegWrite_i,
   input  logic              MemWrite_i,
   input  logic              MemRead_i,
   input  logic              Mem2Reg_i,
   input  logic              Zero_i,
   input  logic [XLEN-1:0]   ALU_data_i,
   input  logic [XLEN-1:0]   writeData_i,
   input  logic [REG_AW-1:0] RDaddr_i,
   output logic              valid_o,
   input  logic              ready_i,
   output logic              RegWrite_o,
   output logic              MemWrite_o,
   output logic              MemRead_o,
   output logic              Mem2Reg_o,
   output logic              Zero_o,
   output logic [XLEN-1:0]   ALU_data_o,
   output logic [XLEN-1:0]   writeData_o,
   output logic [REG_AW-1:0] RDaddr_o,
   output logic [CNT_W-1:0]  stall_cnt_o
);

   // same field order as ex_mem_payload_t, sized by this instance's parameters
   typedef struct packed {
      ex_mem_ctrl_t      ctrl;
      logic              zero;
      logic [XLEN-1:0]   alu;
      logic [XLEN-1:0]   wdata;
      logic [REG_AW-1:0] rd;
   } payload_t;

   payload_t     pl_in, pl_out;
   ex_mem_ctrl_t ctrl_out;

   assign pl_in = {RegWrite_i, MemWrite_i, MemRead_i, Mem2Reg_i, Zero_i, ALU_data_i, writeData_i, RDaddr_i};

   pipe_skid_reg #(.W($bits(payload_t)), .SKID(SKID)) u_reg (
      .clk_i   (clk_i),
      .rst_n_i (rst_n_i),
      .flush_i (flush_i),
      .valid_i (valid_i),
      .ready_o (ready_o),
      .data_i  (pl_in),
      .valid_o (valid_o),
      .ready_i (ready_i),
      .data_o  (pl_out)
   );

   assign ctrl_out    = bubble_ctrl(pl_out.ctrl, valid_o);
   assign RegWrite_o  = ctrl_out.RegWrite;
   assign MemWrite_o  = ctrl_out.MemWrite;
   assign MemRead_o   = ctrl_out.MemRead;
   assign Mem2Reg_o   = ctrl_out.Mem2Reg;
   assign Zero_o      = pl_out.zero;
   assign ALU_data_o  = pl_out.alu;
   assign writeData_o = pl_out.wdata;
   assign RDaddr_o    = pl_out.rd;

   // saturating count of edges where a held entry is refused downstream
   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i)
         stall_cnt_o <= '0;
      else if (valid_o && !ready_i && stall_cnt_o != '1)
         stall_cnt_o <= stall_cnt_o + 1'b1;
   end

endmodule

// File: tb/tb_ex_mem_stage.sv
// tb_ex_mem_stage: directed and randomized checks of both skid settings against a queue model
module tb_ex_mem_stage;

   logic clk = 1'b0, rst_n = 1'b0, flush = 1'b0, vin = 1'b0, rdy_in = 1'b0;
   logic [73:0] pin = '0;
   logic [1:0] rdy_o, vo, rwo, mwo, mro, m2ro, zo;
   logic [1:0][31:0] alo, wdo;
   logic [1:0][4:0] rdo;
   logic [15:0] cnt0;
   logic [3:0] cnt1;
   logic [1:0][15:0] cnt_o;
   logic [1:0][73:0] obs;

   // model: per instance an in-order list of held entries (index 0 = on the outputs)
   logic [73:0] mq [2][2];
   int mn [2], mcnt [2];
   logic [73:0] shown [2];
   logic rdy_ok;
   int checks = 0, failures = 0;

   always #5 clk = ~clk;

   ex_mem_stage #(.SKID(1'b0), .CNT_W(16)) u_dut0 (
      .clk_i(clk), .rst_n_i(rst_n), .flush_i(flush), .valid_i(vin), .ready_o(rdy_o[0]),
      .RegWrite_i(pin[73]), .MemWrite_i(pin[72]), .MemRead_i(pin[71]), .Mem2Reg_i(pin[70]),
      .Zero_i(pin[69]), .ALU_data_i(pin[68:37]), .writeData_i(pin[36:5]), .RDaddr_i(pin[4:0]),
      .valid_o(vo[0]), .ready_i(rdy_in), .RegWrite_o(rwo[0]), .MemWrite_o(mwo[0]),
      .MemRead_o(mro[0]), .Mem2Reg_o(m2ro[0]), .Zero_o(zo[0]), .ALU_data_o(alo[0]),
      .writeData_o(wdo[0]), .RDaddr_o(rdo[0]), .stall_cnt_o(cnt0));

   ex_mem_stage #(.SKID(1'b1), .CNT_W(4)) u_dut1 (
      .clk_i(clk), .rst_n_i(rst_n), .flush_i(flush), .valid_i(vin), .ready_o(rdy_o[1]),
      .RegWrite_i(pin[73]), .MemWrite_i(pin[72]), .MemRead_i(pin[71]), .Mem2Reg_i(pin[70]),
      .Zero_i(pin[69]), .ALU_data_i(pin[68:37]), .writeData_i(pin[36:5]), .RDaddr_i(pin[4:0]),
      .valid_o(vo[1]), .ready_i(rdy_in), .RegWrite_o(rwo[1]), .MemWrite_o(mwo[1]),
      .MemRead_o(mro[1]), .Mem2Reg_o(m2ro[1]), .Zero_o(zo[1]), .ALU_data_o(alo[1]),
      .writeData_o(wdo[1]), .RDaddr_o(rdo[1]), .stall_cnt_o(cnt1));

   // gather each instance's outputs into one payload word and one counter word
   always_comb begin
      cnt_o[0] = cnt0;
      cnt_o[1] = {12'd0, cnt1};
      for (int d = 0; d < 2; d++) obs[d] = {rwo[d], mwo[d], mro[d], m2ro[d], zo[d], alo[d], wdo[d], rdo[d]};
   end

   task automatic check(input string tag, input logic [79:0] got, input logic [79:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   function automatic int cmax(input int d);
      return d == 1 ? 15 : 65535;
   endfunction

   function automatic logic exp_rdy(input int d);
      return rst_n && rdy_ok && (d == 1 ? mn[d] < 2 : (mn[d] == 0 || rdy_in));
   endfunction

   function automatic logic [73:0] rpl(input logic [31:0] a);
      logic [95:0] r;
      r = {$urandom(), $urandom(), $urandom()};
      r[68:37] = a;
      return r[73:0];
   endfunction

   task automatic model_reset();
      for (int d = 0; d < 2; d++) begin
         mn[d] = 0;
         mcnt[d] = 0;
         shown[d] = '0;
      end
      rdy_ok = 1'b0;
   endtask

   task automatic model_edge();
      logic acc [2];
      if (!rst_n) return;
      for (int d = 0; d < 2; d++) acc[d] = vin && exp_rdy(d) && !flush;
      for (int d = 0; d < 2; d++) begin
         if (mn[d] > 0 && !rdy_in && mcnt[d] < cmax(d)) mcnt[d]++;
         if (flush) mn[d] = 0;
         else begin
            if (mn[d] > 0 && rdy_in) begin
               mq[d][0] = mq[d][1];
               mn[d]--;
            end
            if (acc[d]) begin
               mq[d][mn[d]] = pin;
               mn[d]++;
            end
         end
         if (mn[d] > 0) shown[d] = mq[d][0];
      end
      rdy_ok = 1'b1;
   endtask

   task automatic compare();
      logic [73:0] e;
      for (int d = 0; d < 2; d++) begin
         e = shown[d];
         if (mn[d] == 0) e[73:71] = 3'b000;
         check($sformatf("ready%0d", d), rdy_o[d], exp_rdy(d));
         check($sformatf("valid%0d", d), vo[d], mn[d] > 0);
         check($sformatf("payload%0d", d), obs[d], e);
         check($sformatf("stall%0d", d), cnt_o[d], mcnt[d]);
      end
   endtask

   task automatic step(input logic v, input logic r, input logic f, input logic [73:0] p, input logic chk = 1'b1);
      vin = v;
      rdy_in = r;
      flush = f;
      pin = p;
      #1;
      if (chk) compare();
      @(posedge clk);
      model_edge();
      @(negedge clk);
   endtask

   initial begin
      logic [73:0] p;
      @(negedge clk);
      model_reset();
      compare();
      step(1'b0, 1'b0, 1'b0, '0);
      rst_n = 1'b1;
      step(1'b0, 1'b1, 1'b0, '0, 1'b0);
      check("ready_after_release", rdy_o[1], 1);
      for (int i = 1; i <= 8; i++) step(1'b1, 1'b1, 1'b0, rpl(i));
      step(1'b0, 1'b1, 1'b0, rpl(0));
      check("stream_last", alo[1], 8);
      check("stream_stall", cnt_o[1], 0);
      step(1'b1, 1'b1, 1'b0, rpl(32'hA));
      step(1'b1, 1'b0, 1'b0, rpl(32'hB));
      step(1'b1, 1'b0, 1'b0, rpl(32'hC));
      check("bp_ready", rdy_o[1], 0);
      check("bp_out", alo[1], 32'hA);
      step(1'b1, 1'b0, 1'b0, rpl(32'hC));
      check("bp_hold", alo[1], 32'hA);
      step(1'b0, 1'b1, 1'b0, rpl(0));
      check("bp_next", alo[1], 32'hB);
      step(1'b0, 1'b1, 1'b0, rpl(0));
      check("bp_cnt", cnt_o[1], 3);
      step(1'b1, 1'b1, 1'b0, rpl(32'h11));
      step(1'b1, 1'b0, 1'b0, rpl(32'h22));
      step(1'b1, 1'b0, 1'b1, rpl(32'hDEAD));
      check("flush_valid", vo[1], 0);
      check("flush_mw", mwo[1], 0);
      check("flush_ready", rdy_o[1], 1);
      check("flush_alu", alo[1], 32'h11);
      p = rpl(32'h55);
      p[72] = 1'b1;
      step(1'b1, 1'b1, 1'b0, p);
      check("bubble_mw_live", mwo[1], 1);
      step(1'b0, 1'b1, 1'b0, rpl(0));
      check("bubble_mw", mwo[1], 0);
      check("bubble_valid", vo[1], 0);
      check("bubble_alu", alo[1], 32'h55);
      step(1'b1, 1'b1, 1'b0, rpl(32'h77));
      step(1'b1, 1'b0, 1'b0, rpl(32'h78));
      check("s0_ready_low", rdy_o[0], 0);
      check("s0_hold", alo[0], 32'h77);
      rdy_in = 1'b1;
      #1 check("s0_ready_high", rdy_o[0], 1);
      step(1'b1, 1'b1, 1'b0, rpl(32'h79));
      check("s0_b2b", alo[0], 32'h79);
      for (int i = 0; i < 600; i++)
         step($urandom_range(0, 3) != 0, $urandom_range(0, 3) != 0, $urandom_range(0, 15) == 0, rpl($urandom()));
      #2 rst_n = 1'b0;
      #1 model_reset();
      compare();
      step(1'b0, 1'b0, 1'b0, '0);
      rst_n = 1'b1;
      step(1'b0, 1'b1, 1'b0, '0, 1'b0);
      step(1'b1, 1'b1, 1'b0, rpl(32'h99));
      for (int i = 0; i < 20; i++) step(1'b1, 1'b0, 1'b0, rpl($urandom()));
      check("sat_cnt", cnt_o[1], 15);
      check("stall_cnt0", cnt_o[0], 20);
      #2 rst_n = 1'b0;
      #1 model_reset();
      check("rst_valid", vo[1], 0);
      check("rst_cnt", cnt_o[1], 0);
      check("rst_alu", alo[1], 0);
      check("rst_ready", rdy_o[1], 0);
      compare();
      step(1'b1, 1'b0, 1'b0, rpl(1));
      rst_n = 1'b1;
      step(1'b0, 1'b1, 1'b0, '0, 1'b0);
      check("rel_ready", rdy_o[1], 1);
      check("rel_valid", vo[1], 0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
